// File: rtl/fetch_pkg.sv
// Shared fetch-path types and sizes, also imported by the opcode decoder.
package fetch_pkg;

  localparam int FETCH_BYTES  = 8;
  localparam int WIN_BYTES    = 16;
  localparam int MAX_INST_LEN = 15;
  localparam int QDEPTH       = 32;

  typedef logic [7:0] byte_t;
  typedef byte_t [FETCH_BYTES-1:0] fetch_blk_t;
  typedef byte_t [WIN_BYTES-1:0]   window_t;

endpackage

// File: rtl/fetch_window_rotate.sv
// Combinational window extraction: WIN bytes starting at head, bytes beyond
// the valid fill level forced to zero so the decoder never sees stale data.
module fetch_window_rotate
  import fetch_pkg::*;
#(
  parameter int DEPTH = QDEPTH,
  parameter int WIN   = WIN_BYTES,
  parameter int PW    = $clog2(DEPTH),
  parameter int AW    = $clog2(WIN) + 1
) (
  input  byte_t            mem [DEPTH],
  input  logic [PW-1:0]    head,
  input  logic [AW-1:0]    avail,
  output logic [8*WIN-1:0] win_data
);

  // Rotate the circular byte array to head and mask unfilled bytes.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < WIN; i++) begin
      if (AW'(i) < avail) begin
        win_data[8*i +: 8] = mem[head + PW'(i)];
      end
    end
  end

endmodule

// File: rtl/fetch_byte_queue.sv
// Byte-granular instruction queue: aligned fetch blocks in, a 16-byte
// decode window out, variable-length retire from the window head.
module fetch_byte_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = QDEPTH,
  parameter int FETCH = FETCH_BYTES,
  parameter int WIN   = WIN_BYTES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [8*FETCH-1:0]                in_data,
  output logic                              in_ready,
  input  logic                              flush,
  input  logic [63:0]                       flush_pc,
  output logic [8*WIN-1:0]                  win_data,
  output logic [$clog2(WIN):0]              win_avail,
  output logic [63:0]                       win_pc,
  input  logic                              consume,
  input  logic [$clog2(MAX_INST_LEN+1)-1:0] consume_len,
  output logic                              consume_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(WIN) + 1;
  localparam int SW = $clog2(FETCH);
  localparam int LW = $clog2(MAX_INST_LEN + 1);

  byte_t          mem [DEPTH];
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  count;
  logic [63:0]    pc;
  logic [SW-1:0]  skip;
  logic           skip_pend;
  logic           err_q;

  logic [SW-1:0]  skip_amt;
  logic [SW:0]    n_keep;
  logic           wr_en, cons_req, cons_ok;
  logic [CW-1:0]  wr_n, cons_n;

  // Flow control and window fill come from registered count only.
  assign in_ready    = (count <= CW'(DEPTH - FETCH));
  assign win_avail   = (count > CW'(WIN)) ? AW'(WIN) : AW'(count);
  assign win_pc      = pc;
  assign consume_err = err_q;

  // Leading bytes of the first block after a mid-block redirect are dropped.
  assign skip_amt = skip_pend ? skip : '0;
  assign n_keep   = (SW+1)'(FETCH - int'(skip_amt));

  assign wr_en    = in_valid & in_ready & ~flush;
  assign cons_req = consume & ~flush;
  assign cons_ok  = cons_req && (consume_len != '0) && (AW'(consume_len) <= win_avail);
  assign wr_n     = wr_en   ? CW'(n_keep)      : '0;
  assign cons_n   = cons_ok ? CW'(consume_len) : '0;

  // Byte array write: kept bytes of the block land contiguously at tail.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      for (int j = 0; j < FETCH; j++) begin
        if (j >= int'(skip_amt)) begin
          mem[tail + PW'(j) - PW'(skip_amt)] <= in_data[8*j +: 8];
        end
      end
    end
  end

  // Pointer, count, pc and redirect bookkeeping; flush overrides write/consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      pc        <= '0;
      skip      <= '0;
      skip_pend <= 1'b0;
      err_q     <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      pc        <= flush_pc;
      skip      <= flush_pc[SW-1:0];
      skip_pend <= (flush_pc[SW-1:0] != '0);
      err_q     <= 1'b0;
    end else begin
      if (wr_en) begin
        tail      <= tail + PW'(n_keep);
        skip_pend <= 1'b0;
      end
      if (cons_ok) begin
        head <= head + PW'(consume_len);
        pc   <= pc + 64'(consume_len);
      end
      count <= count + wr_n - cons_n;
      err_q <= cons_req & ~cons_ok;
    end
  end

  fetch_window_rotate #(
    .DEPTH (DEPTH),
    .WIN   (WIN)
  ) u_rotate (
    .mem      (mem),
    .head     (head),
    .avail    (win_avail),
    .win_data (win_data)
  );

  logic [LW-1:0] unused_len_w;
  assign unused_len_w = '0;

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Directed bench for fetch_byte_queue.
module tb_fetch_byte_queue;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [63:0]   in_data;
  logic          in_ready;
  logic          flush;
  logic [63:0]   flush_pc;
  logic [127:0]  win_data;
  logic [4:0]    win_avail;
  logic [63:0]   win_pc;
  logic          consume;
  logic [3:0]    consume_len;
  logic          consume_err;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_byte_queue dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .win_data    (win_data),
    .win_avail   (win_avail),
    .win_pc      (win_pc),
    .consume     (consume),
    .consume_len (consume_len),
    .consume_err (consume_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [63:0] p);
    flush = 1'b1; flush_pc = p;
    step();
    flush = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_consume(input logic [3:0] l);
    consume = 1'b1; consume_len = l;
    step();
    consume = 1'b0;
  endtask

  // Block b of a stream whose byte k has value base+k.
  function automatic logic [63:0] blk(input int base, input int b);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = 8'(base + 8*b + j);
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (win_avail !== 5'd0) begin n_bad++; $display("FAIL reset_win_avail got %0d want 0", win_avail); end
    n_cmp++; if (win_pc !== 64'd0) begin n_bad++; $display("FAIL reset_win_pc got %h want 0", win_pc); end
    n_cmp++; if (consume_err !== 1'b0) begin n_bad++; $display("FAIL reset_consume_err got %0b want 0", consume_err); end
    n_cmp++; if (win_data !== 128'd0) begin n_bad++; $display("FAIL reset_win_data got %h want 0", win_data); end
  endtask

  task automatic test_aligned();
    do_flush(64'h400000);
    do_write(64'h0706050403020100);
    n_cmp++; if (win_avail !== 5'd8) begin n_bad++; $display("FAIL aligned_avail got %0d want 8", win_avail); end
    n_cmp++; if (win_data !== 128'h0706050403020100) begin n_bad++; $display("FAIL aligned_data got %h want 0706050403020100", win_data); end
    n_cmp++; if (win_pc !== 64'h400000) begin n_bad++; $display("FAIL aligned_pc got %h want 400000", win_pc); end
  endtask

  task automatic test_unaligned();
    do_flush(64'h400005);
    n_cmp++; if (win_avail !== 5'd0 || win_pc !== 64'h400005 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_state got avail=%0d pc=%h rdy=%0b want 0/400005/1", win_avail, win_pc, in_ready);
    end
    do_write(64'h0706050403020100);
    n_cmp++; if (win_avail !== 5'd3) begin n_bad++; $display("FAIL unaligned_avail got %0d want 3", win_avail); end
    n_cmp++; if (win_data !== 128'h070605) begin n_bad++; $display("FAIL unaligned_data got %h want 070605", win_data); end
    n_cmp++; if (win_pc !== 64'h400005) begin n_bad++; $display("FAIL unaligned_pc got %h want 400005", win_pc); end
    do_write(64'h0f0e0d0c0b0a0908);
    n_cmp++; if (win_avail !== 5'd11) begin n_bad++; $display("FAIL unaligned2_avail got %0d want 11", win_avail); end
    n_cmp++; if (win_data !== 128'h0f0e0d0c0b0a0908070605) begin n_bad++; $display("FAIL unaligned2_data got %h want 0f0e0d0c0b0a0908070605", win_data); end
  endtask

  task automatic test_full_wrap();
    logic [127:0] exp;
    // Advance head to 16 so the later window straddles mem[31] -> mem[0].
    do_flush(64'h1000);
    do_write(64'h1111111111111111);
    do_consume(4'd8);
    do_write(64'h2222222222222222);
    do_consume(4'd8);
    n_cmp++; if (win_avail !== 5'd0 || win_pc !== 64'h1010) begin
      n_bad++; $display("FAIL prewrap got avail=%0d pc=%h want 0/1010", win_avail, win_pc);
    end
    for (int b = 0; b < 3; b++) do_write(blk(8'h40, b));
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ready_at_24 got %0b want 1", in_ready); end
    do_write(blk(8'h40, 3));
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ready_at_32 got %0b want 0", in_ready); end
    // Offer a block while full, together with a consume of 9: block must be dropped.
    in_valid = 1'b1; in_data = 64'hdeadbeefdeadbeef;
    do_consume(4'd9);
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_consume got %0b want 1", in_ready); end
    n_cmp++; if (win_pc !== 64'h1019) begin n_bad++; $display("FAIL wrap_pc got %h want 1019", win_pc); end
    for (int i = 0; i < 16; i++) exp[8*i +: 8] = 8'(8'h40 + 9 + i);
    n_cmp++; if (win_data !== exp) begin n_bad++; $display("FAIL wrap_data got %h want %h", win_data, exp); end
    do_consume(4'd15);
    exp = '0;
    for (int i = 0; i < 8; i++) exp[8*i +: 8] = 8'(8'h40 + 24 + i);
    n_cmp++; if (win_avail !== 5'd8 || win_data !== exp) begin
      n_bad++; $display("FAIL full_drop got avail=%0d data=%h want 8/%h", win_avail, win_data, exp);
    end
    do_consume(4'd8);
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp;
    do_flush(64'h2000);
    do_write(blk(8'h80, 0));
    do_write(blk(8'h80, 1));
    do_consume(4'd6);
    // count=10: write and consume 3 together.
    in_valid = 1'b1; in_data = blk(8'h80, 2);
    do_consume(4'd3);
    in_valid = 1'b0;
    n_cmp++; if (win_avail !== 5'd15) begin n_bad++; $display("FAIL b2b_avail got %0d want 15", win_avail); end
    n_cmp++; if (win_pc !== 64'h2009) begin n_bad++; $display("FAIL b2b_pc got %h want 2009", win_pc); end
    exp = '0;
    for (int i = 0; i < 15; i++) exp[8*i +: 8] = 8'(8'h89 + i);
    n_cmp++; if (win_data !== exp) begin n_bad++; $display("FAIL b2b_data got %h want %h", win_data, exp); end
    do_consume(4'd15);
    n_cmp++; if (win_avail !== 5'd0 || consume_err !== 1'b0 || win_pc !== 64'h2018) begin
      n_bad++; $display("FAIL max_len got avail=%0d err=%0b pc=%h want 0/0/2018", win_avail, consume_err, win_pc);
    end
  endtask

  task automatic test_illegal();
    do_flush(64'h3006);
    do_write(64'h0706050403020100);
    n_cmp++; if (win_avail !== 5'd2 || win_data !== 128'h0706) begin
      n_bad++; $display("FAIL skip6 got avail=%0d data=%h want 2/0706", win_avail, win_data);
    end
    do_consume(4'd4);
    n_cmp++; if (consume_err !== 1'b1 || win_avail !== 5'd2 || win_pc !== 64'h3006) begin
      n_bad++; $display("FAIL over_consume got err=%0b avail=%0d pc=%h want 1/2/3006", consume_err, win_avail, win_pc);
    end
    step();
    n_cmp++; if (consume_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse got %0b want 0", consume_err); end
    do_consume(4'd0);
    n_cmp++; if (consume_err !== 1'b1 || win_avail !== 5'd2) begin
      n_bad++; $display("FAIL zero_len got err=%0b avail=%0d want 1/2", consume_err, win_avail);
    end
    flush = 1'b1; flush_pc = 64'h5000;
    in_valid = 1'b1; in_data = 64'h0102030405060708;
    do_consume(4'd1);
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (win_avail !== 5'd0 || win_pc !== 64'h5000 || in_ready !== 1'b1 || consume_err !== 1'b0) begin
      n_bad++; $display("FAIL flush_prio got avail=%0d pc=%h rdy=%0b err=%0b want 0/5000/1/0", win_avail, win_pc, in_ready, consume_err);
    end
    do_consume(4'd1);
    n_cmp++; if (consume_err !== 1'b1 || win_pc !== 64'h5000) begin
      n_bad++; $display("FAIL empty_consume got err=%0b pc=%h want 1/5000", consume_err, win_pc);
    end
  endtask

  task automatic test_pc_wrap();
    do_flush(64'hffff_ffff_ffff_fffe);
    do_write(64'h0706050403020100);
    n_cmp++; if (win_avail !== 5'd2 || win_data !== 128'h0706) begin
      n_bad++; $display("FAIL wrap_fill got avail=%0d data=%h want 2/0706", win_avail, win_data);
    end
    do_consume(4'd2);
    n_cmp++; if (win_pc !== 64'd0 || win_avail !== 5'd0) begin
      n_bad++; $display("FAIL pc_wrap got pc=%h avail=%0d want 0/0", win_pc, win_avail);
    end
  endtask

  task automatic test_reset_mid();
    do_flush(64'h6000);
    do_write(64'haabbccddeeff0011);
    reset = 1'b1; flush = 1'b1; flush_pc = 64'h7777;
    in_valid = 1'b1; consume = 1'b1; consume_len = 4'd9;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; consume = 1'b0;
    n_cmp++; if (win_avail !== 5'd0 || win_pc !== 64'd0 || in_ready !== 1'b1 || consume_err !== 1'b0 || win_data !== 128'd0) begin
      n_bad++; $display("FAIL reset_mid got avail=%0d pc=%h rdy=%0b err=%0b want 0/0/1/0", win_avail, win_pc, in_ready, consume_err);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; flush_pc = '0;
    consume = 1'b0; consume_len = '0;
    test_reset();
    test_aligned();
    test_unaligned();
    test_full_wrap();
    test_back_to_back();
    test_illegal();
    test_pc_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_byte_queue.md
# fetch_byte_queue

Byte-granular instruction queue between the instruction-fetch port and the opcode decoder. It accepts aligned 8-byte fetch blocks, keeps them as a contiguous byte stream in program order, and presents a 16-byte window starting at the current instruction boundary. The decoder uses window byte 0 (after prefixes) to index its 256-entry opcode-info table. After decoding it returns the instruction length, and the queue retires that many bytes.

## Interface
- DEPTH, 32, queue capacity in bytes (power of two, at least 2×FETCH + WIN).
- FETCH, 8, bytes per fetch block.
- WIN, 16, window bytes presented to the decoder (covers the 15-byte maximum x86 instruction).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  fetch block present.
- in_data  in  64  fetch block; byte 0 is bits [7:0] and the lowest address.
- in_ready  out  1  queue accepts a block this cycle.
- flush  in  1  redirect: discard all contents.
- flush_pc  in  64  new stream address.
- win_data  out  128  bytes [head .. head+15]; byte i is bits [8i+7:8i].
- win_avail  out  5  valid bytes in the window, min(count, 16).
- win_pc  out  64  address of window byte 0.
- consume  in  1  decoder retires bytes this cycle.
- consume_len  in  4  bytes retired, 1..15.
- consume_err  out  1  one-cycle pulse: illegal consume was ignored.

## Operation
- State:
  - byte array mem[DEPTH];
  - head and tail pointers, log2(DEPTH) bits, wrapping modulo DEPTH;
  - count, 6 bits, range 0..32;
  - pc, 64 bits;
  - skip, 3 bits;
  - skip_pend, 1 bit.
- Reset:
  - head, tail, count, skip and skip_pend = 0; pc = 0.
  - Outputs: in_ready=1, win_avail=0, win_pc=0, consume_err=0, win_data=0.
- in_ready = (count <= DEPTH−FETCH). It depends only on registered count and never on same-cycle consume.
- Write (in_valid & in_ready & !flush):
  - Bytes kept: n = skip_pend ? FETCH−skip : FETCH.
  - The kept bytes are in_data bytes [FETCH−n .. FETCH−1], written at tail..tail+n−1 (wrapping).
  - tail += n; count += n; skip_pend clears.
- Consume (consume & !flush):
  - Legal only if 1 ≤ consume_len ≤ win_avail.
  - If legal: head += consume_len; count −= consume_len; pc += consume_len.
  - If illegal: no state change, and consume_err pulses the next cycle.
- Simultaneous write and legal consume: count_next = count + n − consume_len. Both take effect in the same cycle.
- Flush has priority over write and consume in the same cycle:
  - head = tail = count = 0; pc = flush_pc;
  - skip = flush_pc[2:0]; skip_pend = (flush_pc[2:0] ≠ 0).
  - The in_data block presented in the flush cycle is dropped.
  - The first accepted block after the flush is taken to be the aligned block containing flush_pc.
- Window:
  - win_data byte i = mem[(head+i) mod DEPTH] for i < win_avail.
  - Bytes i ≥ win_avail read as 0x00 (deterministic for the bench).
- The pc adder wraps modulo 2^64.

## Timing
- Window outputs are combinational from registers only; there is no path from in_* or consume* to win_*.
- Latency:
  - A block accepted in cycle t is visible in the window in cycle t+1.
  - A consume in cycle t moves the window in cycle t+1.
- Flush in cycle t: in cycle t+1, win_avail=0, win_pc=flush_pc, in_ready=1.
- Reset mid-operation behaves exactly like the reset state, regardless of flush, in_valid or consume in that cycle.
- Full: count > 24 deasserts in_ready. A consume that same cycle does not raise in_ready until the next cycle.
- Empty: win_avail=0. Any consume is illegal and gives consume_err.

## Structure
- Shared package fetch_pkg:
  - FETCH_BYTES=8, WIN_BYTES=16, MAX_INST_LEN=15, QDEPTH=32;
  - typedef byte_t (logic[7:0]);
  - typedef fetch_blk_t (byte_t[FETCH_BYTES]);
  - typedef window_t (byte_t[WIN_BYTES]).
  
  The decoder imports the same MAX_INST_LEN.
- One sub-module, fetch_window_rotate: purely combinational. It selects WIN bytes from the byte array starting at head and zero-masks beyond win_avail. The top level owns all sequential state.

## Test plan
- Reset, then idle → in_ready=1, win_avail=0, win_pc=0, consume_err=0.
- Flush flush_pc=0x400000, then write 0x0706050403020100 → next cycle win_avail=8, win_data[63:0]=0x0706050403020100, win_pc=0x400000.
- Flush flush_pc=0x400005, then write 0x0706050403020100 → win_avail=3, window bytes 05,06,07, win_pc=0x400005. A second block of 8 bytes follows contiguously (win_avail=11).
- Fill to 32 bytes with 4 blocks while not consuming → in_ready=0 after count=32. Consume 9 → in_ready=1 next cycle. The window shows bytes 9..24 of the stream with wrap across mem[31]→mem[0].
- Write a block and consume 3 in the same cycle from count=10 → count=15, win_pc advances by 3. Then consume_len=15 with win_avail=15 → legal, count=0.
- Consume 4 with win_avail=2 → no state change, consume_err=1 for one cycle. Flush asserted together with in_valid and consume → all three are ignored except the flush, and win_avail=0 next cycle.
